div_unit_param: RTL and testbench

//  Parametrised iterative radix-2 integer divider for the RV64 M-extension execute stage.

---
 rtl/div_unit_param.sv | 207 ++++++++++++++++++++
 tb/tb_div_unit_param.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_unit_param.sv
// div_unit_param: iterative radix-2 restoring integer divider for the RV64 M-extension.
// Executes DIV/DIVU/REM/REMU and, when XLEN==64, the W variants DIVW/DIVUW/REMW/REMUW.
// One op is accepted through a valid/ready handshake. Its PRF tag is carried to the result port.
// A zero divisor and signed overflow complete one cycle after accept.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   flush_i           kills any in-flight or held op; returns to idle on the next edge
//   div_valid_i       op request; accepted when div_ready_o=1 and funct3_i[2]=1
//   div_ready_o       unit idle and able to accept
//   funct3_i          100 div, 101 divu, 110 rem, 111 remu
//   is_word_i         W variant: operates on bits [31:0], result sign-extended from bit 31
//   dividend_i        rs1
//   divisor_i         rs2
//   tag_i             destination physical-register tag
//   result_valid_o    result presented; held until result_ready_i
//   result_ready_i    writeback consumes the result
//   result_o          quotient or remainder
//   result_tag_o      tag captured at accept
//   busy_o            unit not idle
module div_unit_param #(
  parameter int unsigned XLEN      = 64,
  parameter int unsigned TAG_WIDTH = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush_i,
  input  logic                 div_valid_i,
  output logic                 div_ready_o,
  input  logic [2:0]           funct3_i,
  input  logic                 is_word_i,
  input  logic [XLEN-1:0]      dividend_i,
  input  logic [XLEN-1:0]      divisor_i,
  input  logic [TAG_WIDTH-1:0] tag_i,
  output logic                 result_valid_o,
  input  logic                 result_ready_i,
  output logic [XLEN-1:0]      result_o,
  output logic [TAG_WIDTH-1:0] result_tag_o,
  output logic                 busy_o
);

  localparam int unsigned CntW   = $clog2(XLEN + 1);
  localparam bit          WordOk = (XLEN == 64);

  typedef enum logic [1:0] {StIdle, StIter, StFix, StDone} state_e;

  function automatic logic [XLEN-1:0] sext32(input logic [XLEN-1:0] x);
    logic [XLEN-1:0] y;
    y = x;
    for (int i = 32; i < XLEN; i++) y[i] = x[31];
    return y;
  endfunction

  function automatic logic [XLEN-1:0] zext32(input logic [XLEN-1:0] x);
    logic [XLEN-1:0] y;
    y = '0;
    y[31:0] = x[31:0];
    return y;
  endfunction

  state_e                 state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [XLEN-1:0]        rem_q, rem_d;
  logic [XLEN-1:0]        quo_q, quo_d;
  logic [XLEN-1:0]        dvs_q, dvs_d;
  logic                   q_neg_q, q_neg_d;
  logic                   r_neg_q, r_neg_d;
  logic                   op_rem_q, op_rem_d;
  logic                   word_q, word_d;
  logic [TAG_WIDTH-1:0]   tag_q, tag_d;
  logic [XLEN-1:0]        result_q, result_d;

  // Operand preparation at accept.
  logic                   word_in, signed_in, accept;
  logic [XLEN-1:0]        a_n, b_n, a_w, a_abs, b_abs, min_n, spec_res;
  logic                   a_neg, b_neg, div_zero, overflow;

  // Iteration datapath.
  logic [XLEN:0]          shifted;
  logic [XLEN-1:0]        sub;
  logic                   ge;

  // Sign fix-up.
  logic [XLEN-1:0]        q_fix, r_fix, fix_res;

  always_comb begin
    word_in   = is_word_i & WordOk;
    signed_in = ~funct3_i[0];
    // Width-N operand, extended to XLEN according to signedness.
    a_n   = word_in ? (signed_in ? sext32(dividend_i) : zext32(dividend_i)) : dividend_i;
    b_n   = word_in ? (signed_in ? sext32(divisor_i) : zext32(divisor_i)) : divisor_i;
    a_w   = word_in ? sext32(dividend_i) : dividend_i;
    a_neg = signed_in & a_n[XLEN-1];
    b_neg = signed_in & b_n[XLEN-1];
    a_abs = a_neg ? -a_n : a_n;
    b_abs = b_neg ? -b_n : b_n;
    min_n = word_in ? ({XLEN{1'b1}} << 31) : {1'b1, {(XLEN-1){1'b0}}};
    div_zero = (b_n == '0);
    overflow = signed_in & (a_n == min_n) & (b_n == {XLEN{1'b1}});
    // Zero divisor: quotient all ones, remainder = dividend. Overflow: quotient = dividend, rem 0.
    if (funct3_i[1]) spec_res = div_zero ? a_w : '0;
    else             spec_res = div_zero ? {XLEN{1'b1}} : a_w;
    accept = (state_q == StIdle) & div_valid_i & funct3_i[2] & ~flush_i;
  end

  always_comb begin
    // The partial remainder stays below the divisor, so XLEN bits hold it between steps;
    // only the shifted value needs the extra bit.
    shifted = {rem_q, quo_q[XLEN-1]};
    ge      = (shifted >= {1'b0, dvs_q});
    sub     = shifted[XLEN-1:0] - dvs_q;
    q_fix   = q_neg_q ? -quo_q : quo_q;
    r_fix   = r_neg_q ? -rem_q : rem_q;
    fix_res = op_rem_q ? r_fix : q_fix;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    q_neg_d  = q_neg_q;
    r_neg_d  = r_neg_q;
    op_rem_d = op_rem_q;
    word_d   = word_q;
    tag_d    = tag_q;
    result_d = result_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          tag_d    = tag_i;
          word_d   = word_in;
          op_rem_d = funct3_i[1];
          if (div_zero | overflow) begin
            result_d = spec_res;
            state_d  = StDone;
          end else begin
            cnt_d   = word_in ? CntW'(32) : CntW'(XLEN);
            rem_d   = '0;
            // W dividends are left-aligned so the step always consumes the MSB.
            quo_d   = word_in ? (a_abs << 32) : a_abs;
            dvs_d   = b_abs;
            q_neg_d = a_neg ^ b_neg;
            r_neg_d = a_neg;
            state_d = StIter;
          end
        end
      end
      StIter: begin
        if (cnt_q == '0) begin
          state_d = StFix;
        end else begin
          rem_d = ge ? sub : shifted[XLEN-1:0];
          quo_d = {quo_q[XLEN-2:0], ge};
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StFix: begin
        result_d = word_q ? sext32(fix_res) : fix_res;
        state_d  = StDone;
      end
      StDone: begin
        if (result_ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (flush_i) state_d = StIdle;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      op_rem_q <= 1'b0;
      word_q   <= 1'b0;
      tag_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      q_neg_q  <= q_neg_d;
      r_neg_q  <= r_neg_d;
      op_rem_q <= op_rem_d;
      word_q   <= word_d;
      tag_q    <= tag_d;
      result_q <= result_d;
    end
  end

  assign div_ready_o    = (state_q == StIdle);
  assign busy_o         = (state_q != StIdle);
  assign result_valid_o = (state_q == StDone);
  assign result_o       = result_q;
  assign result_tag_o   = tag_q;

endmodule

// File: tb/tb_div_unit_param.sv
// Scoreboard bench for div_unit_param (XLEN=64): the driver pushes model results, the monitor
// checks result, tag and latency whenever the unit presents a result.
module tb_div_unit_param;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush_i = 1'b0;
  logic        div_valid_i = 1'b0;
  logic        div_ready_o;
  logic [2:0]  funct3_i = 3'b100;
  logic        is_word_i = 1'b0;
  logic [63:0] dividend_i = '0;
  logic [63:0] divisor_i = '0;
  logic [5:0]  tag_i = '0;
  logic        result_valid_o;
  logic        result_ready_i = 1'b1;
  logic [63:0] result_o;
  logic [5:0]  result_tag_o;
  logic        busy_o;

  div_unit_param #(.XLEN(64), .TAG_WIDTH(6)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush_i       (flush_i),
    .div_valid_i   (div_valid_i),
    .div_ready_o   (div_ready_o),
    .funct3_i      (funct3_i),
    .is_word_i     (is_word_i),
    .dividend_i    (dividend_i),
    .divisor_i     (divisor_i),
    .tag_i         (tag_i),
    .result_valid_o(result_valid_o),
    .result_ready_i(result_ready_i),
    .result_o      (result_o),
    .result_tag_o  (result_tag_o),
    .busy_o        (busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] res;
    logic [5:0]  tag;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   rr_mode = 0;  // 0: always ready, 1: random stalls, 2: held low

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: plain SV signed/unsigned division on the width-N operands.
  function automatic logic [63:0] ref_div(input logic [2:0] f3, input logic w,
                                          input logic [63:0] a, input logic [63:0] b);
    int              sa, sb32;
    int unsigned     ua, ub;
    longint          la, lb;
    longint unsigned ula, ulb;
    logic [31:0]     q32, r32, o32;
    logic [63:0]     q64, r64;
    if (w) begin
      ua = a[31:0]; ub = b[31:0]; sa = a[31:0]; sb32 = b[31:0];
      if (ub == 0) begin q32 = '1; r32 = ua; end
      else if (!f3[0] && sa == 32'sh8000_0000 && sb32 == -1) begin q32 = ua; r32 = 0; end
      else if (!f3[0]) begin q32 = sa / sb32; r32 = sa % sb32; end
      else begin q32 = ua / ub; r32 = ua % ub; end
      o32 = f3[1] ? r32 : q32;
      return {{32{o32[31]}}, o32};
    end
    ula = a; ulb = b; la = a; lb = b;
    if (ulb == 0) begin q64 = '1; r64 = ula; end
    else if (!f3[0] && la == 64'sh8000_0000_0000_0000 && lb == -1) begin q64 = ula; r64 = 0; end
    else if (!f3[0]) begin q64 = la / lb; r64 = la % lb; end
    else begin q64 = ula / ulb; r64 = ula % ulb; end
    return f3[1] ? r64 : q64;
  endfunction

  function automatic int ref_lat(input logic [2:0] f3, input logic w,
                                 input logic [63:0] a, input logic [63:0] b);
    logic zero, ovf;
    if (w) begin
      zero = (b[31:0] == 32'h0);
      ovf  = !f3[0] && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF;
      return (zero || ovf) ? 0 : 34;
    end
    zero = (b == 64'h0);
    ovf  = !f3[0] && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF;
    return (zero || ovf) ? 0 : 66;
  endfunction

  // Monitor: every cycle a result is presented it must match the head of the scoreboard.
  initial begin : monitor
    logic pv;
    pv = 1'b0;
    forever begin
      @(negedge clk);
      if (result_valid_o) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_result: got valid=1 tag %h, expected no pending op",
                   result_tag_o);
        end else begin
          if (!pv) check("latency", 64'(cyc - sb[0].acc - 1), 64'(sb[0].lat));
          check("result", result_o, sb[0].res);
          check("tag", 64'(result_tag_o), 64'(sb[0].tag));
          check("ready_in_done", 64'(div_ready_o), 64'(0));
          if (result_ready_i) void'(sb.pop_front());
        end
      end
      pv = result_valid_o;
    end
  end

  initial begin : ready_gen
    forever begin
      @(posedge clk);
      #1;
      case (rr_mode)
        0:       result_ready_i = 1'b1;
        1:       result_ready_i = ($urandom_range(0, 3) != 0);
        default: result_ready_i = 1'b0;
      endcase
    end
  end

  task automatic issue(input logic [2:0] f3, input logic w, input logic [63:0] a,
                       input logic [63:0] b);
    int   n;
    exp_t e;
    n = 0;
    @(negedge clk);
    while (!div_ready_o && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (!div_ready_o) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: got ready=0 for %0d cycles, expected ready", n);
      return;
    end
    funct3_i = f3; is_word_i = w; dividend_i = a; divisor_i = b;
    tag_i = 6'($urandom);
    div_valid_i = 1'b1;
    @(posedge clk);
    e.acc = cyc;
    e.res = ref_div(f3, w, a, b);
    e.tag = tag_i;
    e.lat = ref_lat(f3, w, a, b);
    sb.push_back(e);
    #1 div_valid_i = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || !div_ready_o) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: got %0d pending, expected 0", sb.size());
    end
  endtask

  task automatic check_reset_outputs(input string tag_name);
    check({tag_name, "_ready"}, 64'(div_ready_o), 64'(1));
    check({tag_name, "_valid"}, 64'(result_valid_o), 64'(0));
    check({tag_name, "_busy"}, 64'(busy_o), 64'(0));
    check({tag_name, "_result"}, result_o, 64'(0));
    check({tag_name, "_tag"}, 64'(result_tag_o), 64'(0));
  endtask

  function automatic logic [63:0] rand_a();
    case ($urandom_range(0, 7))
      0, 1, 2, 3: return {$urandom, $urandom};
      4:          return 64'($urandom_range(0, 50));
      5:          return -64'($urandom_range(1, 50));
      6:          return ($urandom_range(0, 1) != 0) ? 64'h8000_0000_0000_0000
                                                    : {$urandom, 32'h8000_0000};
      default:    return {$urandom, 32'h0} | 64'($urandom_range(0, 100));
    endcase
  endfunction

  function automatic logic [63:0] rand_b();
    case ($urandom_range(0, 7))
      0, 1, 2:    return {$urandom, $urandom};
      3:          return {32'h0, $urandom};
      4:          return 64'($urandom_range(1, 20));
      5:          return -64'($urandom_range(1, 20));
      6:          return ($urandom_range(0, 1) != 0) ? 64'h0 : {$urandom, 32'h0};
      default:    return ($urandom_range(0, 1) != 0) ? 64'hFFFF_FFFF_FFFF_FFFF
                                                    : {$urandom, 32'hFFFF_FFFF};
    endcase
  endfunction

  initial begin : driver
    int n;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    issue(3'b100, 1'b0, 64'd5, -64'd5);
    issue(3'b111, 1'b0, -64'd7, -64'd5);
    issue(3'b101, 1'b0, 64'd7, -64'd5);
    issue(3'b100, 1'b1, 64'hFFFF0000_FFFFFFF9, -64'd5);
    issue(3'b110, 1'b1, 64'hFFFF0000_00000007, -64'd5);
    issue(3'b101, 1'b1, 64'hFFFF0000_10000001, 64'hFFFF0000_10000000);
    issue(3'b100, 1'b0, 64'h1234_5678_9ABC_DEF0, 64'd0);
    issue(3'b100, 1'b0, 64'h8000_0000_0000_0000, -64'd1);
    issue(3'b110, 1'b0, 64'h8000_0000_0000_0000, -64'd1);
    issue(3'b110, 1'b1, 64'd5, 64'd0);
    issue(3'b110, 1'b0, -64'd100, 64'd7);
    drain();

    // Unsupported funct3 is ignored.
    @(negedge clk);
    funct3_i = 3'b010; div_valid_i = 1'b1;
    @(posedge clk);
    #1 div_valid_i = 1'b0;
    @(negedge clk);
    check("bad_f3_ready", 64'(div_ready_o), 64'(1));
    check("bad_f3_busy", 64'(busy_o), 64'(0));

    // Back-pressure: the monitor checks stability every held cycle.
    rr_mode = 2;
    issue(3'b100, 1'b1, 64'hFFFF0000_FFFFFFF9, -64'd5);
    n = 0;
    while (!result_valid_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("hold_valid", 64'(result_valid_o), 64'(1));
    repeat (10) @(negedge clk);
    check("hold_busy", 64'(busy_o), 64'(1));
    rr_mode = 0;
    drain();

    // Flush mid-iteration.
    issue(3'b100, 1'b0, 64'd1000, 64'd3);
    repeat (20) @(negedge clk);
    flush_i = 1'b1;
    @(posedge clk);
    #1 flush_i = 1'b0;
    sb.delete();
    @(negedge clk);
    check("flush_iter_valid", 64'(result_valid_o), 64'(0));
    check("flush_iter_ready", 64'(div_ready_o), 64'(1));
    repeat (80) @(negedge clk);
    check("flush_iter_no_late", 64'(result_valid_o), 64'(0));

    // Flush while a result is held.
    rr_mode = 2;
    issue(3'b100, 1'b0, 64'd9, 64'd0);
    @(negedge clk);
    check("flush_done_pre", 64'(result_valid_o), 64'(1));
    flush_i = 1'b1;
    @(posedge clk);
    #1 flush_i = 1'b0;
    sb.delete();
    rr_mode = 0;
    @(negedge clk);
    check("flush_done_valid", 64'(result_valid_o), 64'(0));

    // Reset mid-iteration.
    issue(3'b101, 1'b0, 64'hDEAD_BEEF_0000_1234, 64'd77);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;

    rr_mode = 1;
    for (int i = 0; i < 150; i++) begin
      issue({1'b1, 2'($urandom_range(0, 3))}, 1'($urandom_range(0, 1)), rand_a(), rand_b());
    end
    drain();
    rr_mode = 0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
